mips_mc_control: RTL
====================

# mips_mc_control

Multi-cycle main control FSM for the MIPS core. It sequences the shared datapath (single memory port, ALU `ula`, `regfile`, PC) through fetch, decode, execute, memory and write-back steps, one instruction at a time. It drives every datapath control line, including the 2-bit ALU operation consumed by `ula_control`. It also supports a variable-latency memory through a ready handshake.

## Interface
Parameters:
- `CNT_W`, 32, width of the retired-instruction counter

Ports:
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `opcode`  in  6  instruction[31:26] from the instruction register
- `mem_ready`  in  1  memory completes the current read/write this cycle
- `pc_write`  out  1  unconditional PC load
- `pc_write_cond`  out  1  PC load if ALU zero flag set (datapath ANDs with zero)
- `i_or_d`  out  1  memory address select: 0 = PC, 1 = ALU result register
- `mem_read`  out  1  memory read request
- `mem_write`  out  1  memory write request
- `ir_write`  out  1  instruction register load
- `mem_to_reg`  out  1  write-back data select: 1 = memory data register
- `reg_dst`  out  1  destination select: 1 = rd, 0 = rt
- `reg_write`  out  1  register file write enable
- `alu_src_a`  out  1  0 = PC, 1 = rs data
- `alu_src_b`  out  2  00 = rt data, 01 = constant 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- `ula_operation`  out  2  00 = add, 01 = subtract, 10 = funct-driven
- `pc_source`  out  2  00 = ALU result, 01 = ALU-out register, 10 = jump target
- `state`  out  4  current FSM state (debug)
- `illegal_op`  out  1  one-cycle pulse on unsupported opcode
- `retired`  out  CNT_W  instructions completed since reset

## Operation
- Moore FSM; outputs decode from `state`, except `pc_write` and `ir_write` in FETCH, which are also gated by `mem_ready`.
- States use the following encoding:
  - BOOT=0
  - FETCH=1
  - DECODE=2
  - MEM_ADDR=3
  - MEM_RD=4
  - MEM_WB=5
  - MEM_WR=6
  - R_EXEC=7
  - R_WB=8
  - BRANCH=9
  - JUMP=10
  - ADDI_EX=11
  - ADDI_WB=12
- BOOT: all outputs 0. Next state is FETCH unconditionally.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, ula_operation=00, pc_source=00.
  - While mem_ready=0, stay in FETCH with ir_write=pc_write=0.
  - When mem_ready=1, assert ir_write=pc_write=1 and go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, ula_operation=00 (branch target precompute). Next state by opcode:
  - 000000 → R_EXEC
  - 100011 or 101011 → MEM_ADDR
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000 → ADDI_EX
  - any other opcode → FETCH with illegal_op=1 for that cycle; `retired` is not incremented.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ula_operation=00. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, i_or_d=1. Holds until mem_ready=1, then goes to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Then FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Holds until mem_ready=1, then goes to FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, ula_operation=10. Then R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, ula_operation=01, pc_write_cond=1, pc_source=01. Then FETCH.
- JUMP: pc_write=1, pc_source=10. Then FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, ula_operation=00. Then ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Then FETCH.
- `retired` increments by 1 on every transition from MEM_WB, MEM_WR (with mem_ready=1), R_WB, BRANCH, JUMP or ADDI_WB back to FETCH.
- `retired` wraps modulo 2^CNT_W.
- `opcode` is sampled only in DECODE and MEM_ADDR; all other states ignore it.

## Timing
- Reset (async assert): state=BOOT, retired=0, every output 0 immediately and while reset is held.
- After reset deassertion, first FETCH is one clock after the first rising edge.
- Reset asserted mid-instruction aborts it at once. Writes in flight are dropped and retired is not incremented.
- Cycles per instruction with mem_ready tied to 1:
  - R-type 4
  - lw 5
  - sw 4
  - beq 3
  - j 3
  - addi 4
  - illegal 2
- Each wait cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- Request outputs (mem_read / mem_write, i_or_d) stay stable across wait cycles.
- mem_ready is ignored in all states without a memory request.

## Structure
- Shared include `mips_ctrl_defs.v` holds:
  - state encodings
  - opcode constants (R, LW, SW, BEQ, J, ADDI)
  - ula_operation, alu_src_b and pc_source codes

  `ula_control` uses the same ula_operation codes.
- Sub-module `mips_ctrl_decode`: purely combinational, state + mem_ready → control outputs.
- `mips_mc_control` itself holds only the state register, next-state logic and the `retired` counter.

## Test plan
- Reset then mem_ready=1, opcode=000000: states 0→1→2→7→8→1. reg_write=1 only in R_WB, ula_operation=10 in R_EXEC, retired=1.
- lw (100011) with mem_ready=0 for 3 cycles in MEM_RD: MEM_RD lasts 4 cycles with mem_read=1, i_or_d=1 stable. Instruction takes 8 cycles, retired=1.
- sw (101011) then beq (000100): mem_write=1 only in MEM_WR. BRANCH asserts pc_write_cond=1, pc_source=01, ula_operation=01. retired=2 after 7 cycles.
- opcode=111111: illegal_op pulses 1 cycle in DECODE, FETCH follows, retired unchanged.
- Assert reset during MEM_WR: all outputs 0 asynchronously, state=BOOT, retired=0.
- Preload retired to 2^CNT_W−1 (force or small CNT_W=4) and run j (000010): retired wraps to 0, jump asserts pc_write=1, pc_source=10.

Source files
------------

// File: rtl/mips_mc_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states, opcodes,
// ALU/mux select codes and the bundle of datapath control lines.
package mips_mc_control_pkg;

    typedef enum logic [3:0] {
        ST_BOOT     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_MEM_WB   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_R_EXEC   = 4'd7,
        ST_R_WB     = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JUMP     = 4'd10,
        ST_ADDI_EX  = 4'd11,
        ST_ADDI_WB  = 4'd12
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    // ula_operation codes, shared with ula_control
    localparam logic [1:0] ULA_ADD   = 2'b00;
    localparam logic [1:0] ULA_SUB   = 2'b01;
    localparam logic [1:0] ULA_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] ula_operation;
        logic [1:0] pc_source;
    } ctrl_t;

    // True on the cycle whose clock edge completes an instruction.
    function automatic logic retires(state_e s, logic mem_ready);
        case (s)
            ST_MEM_WB, ST_R_WB, ST_BRANCH, ST_JUMP, ST_ADDI_WB: retires = 1'b1;
            ST_MEM_WR:                                          retires = mem_ready;
            default:                                            retires = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational decode of the control FSM state (plus mem_ready in FETCH)
// into the datapath control lines.
module mips_ctrl_decode
    import mips_mc_control_pkg::*;
(
    input  state_e state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read      = 1'b1;
                ctrl.alu_src_b     = SRCB_FOUR;
                ctrl.ula_operation = ULA_ADD;
                ctrl.pc_source     = PCSRC_ALU;
                ctrl.ir_write      = mem_ready;
                ctrl.pc_write      = mem_ready;
            end
            ST_DECODE: begin
                // Branch target computed speculatively while decoding
                ctrl.alu_src_b     = SRCB_IMM_SH2;
                ctrl.ula_operation = ULA_ADD;
            end
            ST_MEM_ADDR, ST_ADDI_EX: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_IMM;
                ctrl.ula_operation = ULA_ADD;
            end
            ST_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            ST_R_EXEC: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_RT;
                ctrl.ula_operation = ULA_FUNCT;
            end
            ST_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_RT;
                ctrl.ula_operation = ULA_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            ST_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS main control: state register, next-state logic and the
// retired-instruction counter; control lines come from mips_ctrl_decode.
module mips_mc_control
    import mips_mc_control_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       ula_operation,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             known_op;
    ctrl_t            ctrl;

    always_comb begin
        known_op = (opcode == OP_R)  || (opcode == OP_LW) || (opcode == OP_SW) ||
                   (opcode == OP_BEQ) || (opcode == OP_J) || (opcode == OP_ADDI);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:     state_d = ST_FETCH;
            ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_R:         state_d = ST_R_EXEC;
                    OP_LW, OP_SW: state_d = ST_MEM_ADDR;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    OP_ADDI:      state_d = ST_ADDI_EX;
                    default:      state_d = ST_FETCH;
                endcase
            end
            ST_MEM_ADDR: state_d = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   if (mem_ready) state_d = ST_MEM_WB;
            ST_MEM_WR:   if (mem_ready) state_d = ST_FETCH;
            ST_R_EXEC:   state_d = ST_R_WB;
            ST_ADDI_EX:  state_d = ST_ADDI_WB;
            ST_MEM_WB, ST_R_WB, ST_BRANCH, ST_JUMP, ST_ADDI_WB:
                         state_d = ST_FETCH;
            default:     state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        retired_d = retired_q;
        if (retires(state_q, mem_ready))
            retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_BOOT;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    mips_ctrl_decode u_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign ula_operation = ctrl.ula_operation;
    assign pc_source     = ctrl.pc_source;
    assign state         = state_q;
    assign illegal_op    = (state_q == ST_DECODE) && !known_op;
    assign retired       = retired_q;

endmodule
